// File: rtl/player_input_arbiter_if.sv
// Player button arbiter bus: enable/clear and raw buttons in,
// latched winner flag, winner index and debounced levels out.
interface player_input_arbiter_if;
  logic       en;
  logic [3:0] btn;
  logic       clear;
  logic       playerInputFlag;
  logic [1:0] winner;
  logic [3:0] btnLevel;

  // Processor/board side drives controls and buttons.
  modport master (
    output en, btn, clear,
    input  playerInputFlag, winner, btnLevel
  );

  // Arbiter side consumes controls and buttons, reports the result.
  modport slave (
    input  en, btn, clear,
    output playerInputFlag, winner, btnLevel
  );
endinterface

// File: rtl/player_input_arbiter.sv
// Player input arbiter: two-flop synchronizer and per-button debounce,
// rising-edge press detection, first-press latch with fixed priority
// (player 1 highest), held until clear, then re-armed once every
// button is released.
module player_input_arbiter #(
  parameter int NUM_PLAYERS     = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_WIDTH       = 16
) (
  input logic                   clk,
  input logic                   rst,
  player_input_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    ARMED        = 2'd0,
    LOCKED       = 2'd1,
    WAIT_RELEASE = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic [NUM_PLAYERS-1:0] s1_q, s2_q;
  logic [NUM_PLAYERS-1:0] btn_level_q, btn_level_d;
  logic [NUM_PLAYERS-1:0] btn_level_dly_q;
  logic [NUM_PLAYERS-1:0] press;
  logic [1:0]             win_idx;

  state_t     state_q, state_d;
  logic       flag_q, flag_d;
  logic [1:0] winner_q, winner_d;

  // Synchronize raw buttons and register the debounced level plus its delayed copy.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q            <= '0;
      s2_q            <= '0;
      btn_level_q     <= '0;
      btn_level_dly_q <= '0;
    end else begin
      s1_q            <= bus.btn;
      s2_q            <= s1_q;
      btn_level_q     <= btn_level_d;
      btn_level_dly_q <= btn_level_q;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PLAYERS; gi++) begin : g_debounce
      logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
      logic                 lvl_d;

      // Count consecutive cycles where the synchronized input disagrees with the level.
      always_comb begin
        cnt_d = cnt_q + 1'b1;
        lvl_d = btn_level_q[gi];
        if (s2_q[gi] == btn_level_q[gi]) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          lvl_d = s2_q[gi];
          cnt_d = '0;
        end
      end

      // Debounce counter register.
      always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
      end

      assign btn_level_d[gi] = lvl_d;
    end
  endgenerate

  assign press = btn_level_q & ~btn_level_dly_q;

  // Lowest set press index wins; the loop runs high-to-low so index 0 overrides.
  always_comb begin
    win_idx = '0;
    for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
      if (press[i]) win_idx = 2'(i);
    end
  end

  // Arbitration state machine: next state and next registered outputs.
  always_comb begin
    state_d  = state_q;
    flag_d   = flag_q;
    winner_d = winner_q;
    case (state_q)
      ARMED: begin
        if (bus.en && (|press)) begin
          flag_d   = 1'b1;
          winner_d = win_idx;
          state_d  = LOCKED;
        end
      end
      LOCKED: begin
        if (bus.clear) begin
          flag_d   = 1'b0;
          winner_d = 2'd0;
          state_d  = WAIT_RELEASE;
        end
      end
      WAIT_RELEASE: begin
        if (btn_level_q == '0) state_d = ARMED;
      end
      default: begin
        flag_d   = 1'b0;
        winner_d = 2'd0;
        state_d  = ARMED;
      end
    endcase
  end

  // State and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ARMED;
      flag_q   <= 1'b0;
      winner_q <= 2'd0;
    end else begin
      state_q  <= state_d;
      flag_q   <= flag_d;
      winner_q <= winner_d;
    end
  end

  assign bus.playerInputFlag = flag_q;
  assign bus.winner          = winner_q;
  assign bus.btnLevel        = btn_level_q;

endmodule

// File: tb/tb_player_input_arbiter.sv
// Directed bench for player_input_arbiter with a short debounce window.
module tb_player_input_arbiter;

  localparam int DB = 4;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  player_input_arbiter_if bus ();

  player_input_arbiter #(
    .NUM_PLAYERS    (4),
    .DEBOUNCE_CYCLES(DB),
    .CNT_WIDTH      (16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic flag, input logic [1:0] win,
                         input logic [3:0] lvl);
    chk({tag, "_flag"},   {7'd0, bus.playerInputFlag}, {7'd0, flag});
    chk({tag, "_winner"}, {6'd0, bus.winner},          {6'd0, win});
    chk({tag, "_level"},  {4'd0, bus.btnLevel},        {4'd0, lvl});
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    rst       = 1'b1;
    bus.en    = 1'b1;
    bus.btn   = 4'b0000;
    bus.clear = 1'b0;

    // Reset state.
    step(2);
    chk_out("reset", 1'b0, 2'd0, 4'b0000);
    rst = 1'b0;
    step(2);

    // Latency and priority: first sampling edge is edge 0.
    bus.btn = 4'b0100;
    step(5);                                   // after edge 4
    chk_out("lat_e4", 1'b0, 2'd0, 4'b0000);
    step(1);                                   // after edge 5
    chk_out("lat_e5", 1'b0, 2'd0, 4'b0100);
    step(1);                                   // after edge 6
    chk_out("lat_e6", 1'b1, 2'd2, 4'b0100);
    bus.clear = 1'b1;
    step(1);
    bus.clear = 1'b0;
    chk_out("lat_clr", 1'b0, 2'd0, 4'b0100);
    bus.btn = 4'b0000;
    step(8);
    chk_out("lat_rel", 1'b0, 2'd0, 4'b0000);

    // Glitch rejection: 3-cycle pulse never reaches the level.
    bus.btn = 4'b0001;
    step(3);
    bus.btn = 4'b0000;
    step(3);                                   // after edge 5
    chk_out("glitch_e5", 1'b0, 2'd0, 4'b0000);
    step(6);
    chk_out("glitch_end", 1'b0, 2'd0, 4'b0000);

    // A 5-cycle pulse debounces and latches player 1.
    bus.btn = 4'b0001;
    step(5);
    bus.btn = 4'b0000;
    step(2);                                   // after edge 6
    chk_out("pulse5", 1'b1, 2'd0, 4'b0001);
    step(6);
    chk_out("pulse5_hold", 1'b1, 2'd0, 4'b0000);
    bus.clear = 1'b1;
    step(1);
    bus.clear = 1'b0;
    step(3);
    chk_out("pulse5_clr", 1'b0, 2'd0, 4'b0000);

    // Simultaneous press resolves to the lowest index.
    bus.btn = 4'b1010;
    step(7);
    chk_out("simul", 1'b1, 2'd1, 4'b1010);
    bus.btn = 4'b1011;                         // later press while locked
    step(8);
    chk_out("locked_press", 1'b1, 2'd1, 4'b1011);

    // Clear while buttons held; no retrigger.
    bus.btn   = 4'b0010;
    bus.clear = 1'b1;
    step(1);
    bus.clear = 1'b0;
    chk("clr_flag",   {7'd0, bus.playerInputFlag}, 8'd0);
    chk("clr_winner", {6'd0, bus.winner},          8'd0);
    step(10);
    chk_out("clr_held", 1'b0, 2'd0, 4'b0010);
    bus.btn = 4'b0000;
    step(8);
    chk_out("rearm_rel", 1'b0, 2'd0, 4'b0000);
    bus.btn = 4'b1000;
    step(7);
    chk_out("rearm_p4", 1'b1, 2'd3, 4'b1000);
    bus.clear = 1'b1;
    step(1);
    bus.clear = 1'b0;
    bus.btn   = 4'b0000;
    step(10);
    chk_out("rearm_rel2", 1'b0, 2'd0, 4'b0000);

    // Enable low discards the press; raising en later does not queue it.
    bus.en  = 1'b0;
    bus.btn = 4'b0100;
    step(8);
    chk_out("en_off", 1'b0, 2'd0, 4'b0100);
    bus.en = 1'b1;
    step(5);
    chk_out("en_late", 1'b0, 2'd0, 4'b0100);
    bus.btn = 4'b0000;
    step(8);

    // Clear and a new press in the same locked cycle: clear wins.
    bus.btn = 4'b0001;
    step(7);
    chk_out("coll_lock", 1'b1, 2'd0, 4'b0001);
    bus.btn = 4'b0101;
    step(6);                                   // btn[2] level rose at edge 5
    chk_out("coll_pre", 1'b1, 2'd0, 4'b0101);
    bus.clear = 1'b1;
    step(1);
    bus.clear = 1'b0;
    chk_out("coll_clr", 1'b0, 2'd0, 4'b0101);
    step(2);
    chk_out("coll_after", 1'b0, 2'd0, 4'b0101);
    bus.btn = 4'b0000;
    step(10);

    // Reset mid-lock with a counter mid-count.
    bus.btn = 4'b0010;
    step(7);
    chk_out("rst_lock", 1'b1, 2'd1, 4'b0010);
    bus.btn = 4'b0011;
    step(3);
    rst = 1'b1;
    step(1);
    chk_out("rst_mid", 1'b0, 2'd0, 4'b0000);
    rst = 1'b0;
    step(6);                                   // after edge DB+1
    chk_out("rst_e5", 1'b0, 2'd0, 4'b0011);
    step(1);                                   // after edge DB+2
    chk_out("rst_e6", 1'b1, 2'd0, 4'b0011);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
